cve2_instr_mem_responder: RTL and testbench
===========================================

Name: cve2_instr_mem_responder

Overview:
- Responder (memory) end of the core instruction-fetch bus: answers prefetch-buffer requests (req/gnt/rvalid/rdata/err) that ultimately fill the fetch FIFO.
- Backs them with a single-port, fixed-latency SRAM macro.
- Shares that SRAM with a write-only loader port (boot/debug image load); the loader has priority.
- Out-of-range fetches are answered in order with err_o, with no SRAM access.

Parameters:
- MAX_OUTSTANDING, 2: maximum granted-but-unanswered core requests (matches the prefetch NUM_REQS).
- MEM_LATENCY, 1: SRAM read latency in cycles, >=1.
- MEM_WORDS, 1024: SRAM depth in 32-bit words, power of two; AW = $clog2(MEM_WORDS).
- BASE_ADDR, 32'h0000_0000: byte base address; 4*MEM_WORDS-aligned.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  1  core fetch request
- gnt_o  out  1  request accepted this cycle
- addr_i  in  32  fetch byte address; bits [1:0] ignored
- rvalid_o  out  1  response valid; no backpressure
- rdata_o  out  32  response data
- err_o  out  1  response error
- ld_req_i  in  1  loader write request
- ld_gnt_o  out  1  loader write accepted
- ld_addr_i  in  32  loader byte address
- ld_wdata_i  in  32  loader write data
- mem_req_o  out  1  SRAM access strobe
- mem_we_o  out  1  SRAM write enable
- mem_addr_o  out  AW  SRAM word address
- mem_wdata_o  out  DW  SRAM write data (DW=32, or 33 with parity)
- mem_rdata_i  in  DW  SRAM read data, valid MEM_LATENCY cycles after a read strobe

Behaviour:
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, ld_gnt_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0; outstanding counter=0; response pipeline cleared.
- Reset mid-operation drops all in-flight responses; no rvalid_o after reset release for pre-reset grants.
- in_range(a) = (a >= BASE_ADDR) && (a < BASE_ADDR + 4*MEM_WORDS); word index = (a - BASE_ADDR) >> 2, truncated to AW bits.
- Arbitration is combinational, one access per cycle:
  - ld_gnt_o = ld_req_i.
  - gnt_o = req_i & ~ld_req_i & (outstanding < MAX_OUTSTANDING).
- Loader grant:
  - In range: mem_req_o=1, mem_we_o=1, mem_addr_o=index, mem_wdata_o=data.
  - Out of range: the write is silently dropped (mem_req_o=0), ld_gnt_o still 1.
- Core grant, in range: mem_req_o=1, mem_we_o=0, mem_addr_o=index. Push {valid=1, err=0} into the response pipeline.
- Core grant, out of range: no SRAM access. Push {valid=1, err=1}.
- Response pipeline:
  - Shift register of depth MEM_LATENCY, advancing every cycle.
  - Stage MEM_LATENCY-1 drives rvalid_o/err_o, so rvalid_o is exactly MEM_LATENCY cycles after gnt_o.
  - Responses return strictly in grant order.
- rdata_o = mem_rdata_i when rvalid_o & ~err_o, else 32'h0. rdata_o is not registered: combinational from the SRAM output.
- Outstanding counter, width $clog2(MAX_OUTSTANDING+1):
  - +1 on gnt_o, -1 on rvalid_o; unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUTSTANDING.
- When MEM_LATENCY > MAX_OUTSTANDING, throughput is limited to MAX_OUTSTANDING grants per MEM_LATENCY window.
- Simultaneous core and loader requests: loader wins; the core request stays pending (req_i held by the initiator).
- Back-to-back grants are allowed every cycle when the counter permits (the decrement in the same cycle is counted).
- Address wrap: BASE_ADDR + 4*MEM_WORDS - 4 is the last valid word; the next word errors.
- Assertions:
  - rvalid_o never asserted while outstanding==0.
  - mem_req_o implies exactly one of the loader or the core was granted.

Optional Feature:
- Macro CVE2_IMEM_PARITY_EN.
- Defined:
  - DW=33; mem_wdata_o[32] = ^ld_wdata_i.
  - On an in-range read response, if ^mem_rdata_i[32:0] == 1 then err_o=1 and rdata_o=0.
- Undefined:
  - DW=32, no parity bit, no check.
  - err_o only from out-of-range addresses.

Test Plan:
- Load: ld writes 32'hDEAD_BEEF to BASE+0x10 -> mem_we_o=1, mem_addr_o=4. Then core fetch of 0x10 with MEM_LATENCY=1 -> rvalid_o one cycle after gnt_o, rdata_o=32'hDEAD_BEEF, err_o=0.
- Back-to-back: req_i held 4 cycles, MAX_OUTSTANDING=2, MEM_LATENCY=1 -> gnt_o every cycle, rvalid_o every cycle from cycle 1, counter never >1. Repeat with MEM_LATENCY=3 -> gnt_o pattern 1,1,0,1,1,0..., counter peaks at 2.
- Out of range: fetch of BASE + 4*MEM_WORDS (0x1000) -> mem_req_o=0, rvalid_o after MEM_LATENCY with err_o=1, rdata_o=0. A prior in-range fetch answers first.
- Contention: ld_req_i and req_i both high for 2 cycles -> ld_gnt_o=1, gnt_o=0 for both cycles, then gnt_o=1 on cycle 3.
- Reset mid-flight: assert rst_ni=0 one cycle after gnt_o with MEM_LATENCY=2 -> no rvalid_o after release, counter=0, next fetch behaves normally.
- Parity (CVE2_IMEM_PARITY_EN): force mem_rdata_i bit 5 flipped on a read -> err_o=1, rdata_o=0. Without the macro the same stimulus gives err_o=0.

Source files
------------

// File: rtl/cve2_instr_mem_responder.sv
// cve2_instr_mem_responder: instruction-fetch memory responder over a single-port fixed-latency SRAM shared with a loader.
// Optional SRAM parity bit and read check enabled by defining CVE2_IMEM_PARITY_EN.
module cve2_instr_mem_responder #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned MEM_LATENCY     = 1,
    parameter int unsigned MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    localparam int unsigned AW             = $clog2(MEM_WORDS),
`ifdef CVE2_IMEM_PARITY_EN
    localparam int unsigned DW             = 33
`else
    localparam int unsigned DW             = 32
`endif
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_i,
    output logic          gnt_o,
    input  logic [31:0]   addr_i,
    output logic          rvalid_o,
    output logic [31:0]   rdata_o,
    output logic          err_o,
    input  logic          ld_req_i,
    output logic          ld_gnt_o,
    input  logic [31:0]   ld_addr_i,
    input  logic [31:0]   ld_wdata_i,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + 33'(4 * MEM_WORDS);

    logic [31:0]          w_core_off;
    logic [31:0]          w_ld_off;
    logic                 w_core_inr;
    logic                 w_ld_inr;
    logic                 w_perr;
    logic [DW-1:0]        w_ld_wdata;
    logic                 w_unused_off;
    logic [MEM_LATENCY-1:0] r_vld;
    logic [MEM_LATENCY-1:0] r_err;
    logic [CW-1:0]        r_cnt;

    assign w_core_off = addr_i - BASE_ADDR;
    assign w_ld_off   = ld_addr_i - BASE_ADDR;
    assign w_core_inr = ({1'b0, addr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, addr_i} < END_ADDR);
    assign w_ld_inr   = ({1'b0, ld_addr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, ld_addr_i} < END_ADDR);
    assign w_unused_off = ^{w_core_off[31:AW+2], w_core_off[1:0], w_ld_off[31:AW+2], w_ld_off[1:0]};

`ifdef CVE2_IMEM_PARITY_EN
    assign w_ld_wdata = {^ld_wdata_i, ld_wdata_i};
    assign w_perr     = ^mem_rdata_i;
`else
    assign w_ld_wdata = ld_wdata_i;
    assign w_perr     = 1'b0;
`endif

    // A response leaving this cycle frees its slot for a same-cycle grant
    assign ld_gnt_o = rst_ni & ld_req_i;
    assign gnt_o    = rst_ni & req_i & ~ld_req_i & ((r_cnt < CW'(MAX_OUTSTANDING)) | rvalid_o);

    assign mem_req_o   = ld_gnt_o ? w_ld_inr : (gnt_o & w_core_inr);
    assign mem_we_o    = ld_gnt_o & w_ld_inr;
    assign mem_addr_o  = ~mem_req_o ? '0 : ld_gnt_o ? w_ld_off[AW+1:2] : w_core_off[AW+1:2];
    assign mem_wdata_o = mem_we_o ? w_ld_wdata : '0;

    assign rvalid_o = r_vld[MEM_LATENCY-1];
    assign err_o    = rvalid_o & (r_err[MEM_LATENCY-1] | w_perr);
    assign rdata_o  = (rvalid_o & ~err_o) ? mem_rdata_i[31:0] : 32'h0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld <= '0;
            r_err <= '0;
            r_cnt <= '0;
        end else begin
            r_vld <= MEM_LATENCY'({r_vld, gnt_o});
            r_err <= MEM_LATENCY'({r_err, gnt_o & ~w_core_inr});
            r_cnt <= r_cnt + CW'(gnt_o) - CW'(rvalid_o);
        end
    end

`ifndef SYNTHESIS
    a_rvalid_cnt: assert property (@(posedge clk_i) disable iff (!rst_ni) rvalid_o |-> (r_cnt != '0));
    a_mem_owner:  assert property (@(posedge clk_i) disable iff (!rst_ni) mem_req_o |-> (ld_gnt_o ^ gnt_o));
`endif
endmodule

// File: tb/tb_cve2_instr_mem_responder.sv
// tb_cve2_instr_mem_responder: randomized and directed checks against a response-queue reference model.
module tb_cve2_instr_mem_responder;
    localparam int MAXO  = 2;
    localparam int LAT   = 3;
    localparam int WORDS = 1024;
    localparam int AW    = $clog2(WORDS);
    localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef CVE2_IMEM_PARITY_EN
    localparam int DW = 33;
    localparam int PAR = 1;
`else
    localparam int DW = 32;
    localparam int PAR = 0;
`endif

    logic clk, rst_n, req, ld_req;
    logic [31:0] addr, ld_addr, ld_wdata;
    logic gnt_o, rvalid_o, err_o, ld_gnt_o, mem_req_o, mem_we_o;
    logic [31:0] rdata_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o, mem_rdata_i, flip;

    typedef struct { int due; bit err; logic [31:0] data; } resp_t;
    resp_t q[$];
    logic [31:0]   gm [WORDS];
    logic [DW-1:0] sram [WORDS];
    logic [DW-1:0] rd_pipe [LAT];
    int cyc, total, bad;
    logic m_gnt, m_rv, m_err, m_mreq, m_we;
    logic [31:0] m_data;
    logic [AW-1:0] m_maddr;

    cve2_instr_mem_responder #(
        .MAX_OUTSTANDING(MAXO), .MEM_LATENCY(LAT), .MEM_WORDS(WORDS), .BASE_ADDR(BASE)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_o), .addr_i(addr),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .ld_req_i(ld_req), .ld_gnt_o(ld_gnt_o), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    assign mem_rdata_i = rd_pipe[LAT-1] ^ flip;

    function automatic bit inr(input logic [31:0] a);
        return ({32'h0, a} >= {32'h0, BASE}) && ({32'h0, a} < {32'h0, BASE} + 64'(4 * WORDS));
    endfunction

    function automatic int idx(input logic [31:0] a);
        return int'((a - BASE) >> 2) & (WORDS - 1);
    endfunction

    function automatic logic [DW-1:0] enc(input logic [31:0] d);
`ifdef CVE2_IMEM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    function automatic logic [31:0] rnd_addr();
        case ($urandom % 8)
            0: return BASE + 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 15));
            1: return BASE - 32'(4 * $urandom_range(1, 4));
            2: return $urandom;
            3: return BASE + 32'(4 * WORDS - 4);
            default: return BASE + 32'($urandom_range(0, 4 * WORDS - 1));
        endcase
    endfunction

    // Outstanding = queued responses not yet due; one due this cycle frees its slot
    function automatic void eval();
        int live = 0;
        foreach (q[i]) if (q[i].due > cyc) live++;
        m_gnt   = rst_n && req && !ld_req && (live < MAXO);
        m_rv    = rst_n && (q.size() > 0) && (q[0].due == cyc);
        m_err   = m_rv && (q[0].err || (PAR == 1 && ^flip));
        m_data  = (m_rv && !m_err) ? (q[0].data ^ flip[31:0]) : 32'h0;
        m_mreq  = rst_n && (ld_req ? inr(ld_addr) : (m_gnt && inr(addr)));
        m_we    = rst_n && ld_req && inr(ld_addr);
        m_maddr = !m_mreq ? '0 : ld_req ? AW'(idx(ld_addr)) : AW'(idx(addr));
    endfunction

    always @(posedge clk) begin
        eval();
        if (!rst_n) q.delete();
        else begin
            if (m_rv) void'(q.pop_front());
            if (m_gnt) q.push_back('{due: cyc + LAT, err: !inr(addr), data: gm[idx(addr)]});
            if (ld_req && inr(ld_addr)) gm[idx(ld_addr)] = ld_wdata;
        end
        cyc++;
    end

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= (mem_req_o && !mem_we_o) ? sram[mem_addr_o] : '0;
        if (mem_req_o && mem_we_o) sram[mem_addr_o] <= mem_wdata_o;
    end

    task automatic idle(input int n);
        req = 0;
        ld_req = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 0; req = 1; ld_req = 1; addr = BASE; ld_addr = BASE + 4; ld_wdata = 32'h1234_5678;
        @(negedge clk);
        total++;
        if ({gnt_o, ld_gnt_o, rvalid_o, err_o, mem_req_o, mem_we_o} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 000000", {gnt_o, ld_gnt_o, rvalid_o, err_o, mem_req_o, mem_we_o});
        end
        total++;
        if (rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata_o); end
        total++;
        if (mem_addr_o !== '0 || mem_wdata_o !== '0) begin
            bad++; $display("FAIL reset_mem: got addr %h wdata %h want 0", mem_addr_o, mem_wdata_o);
        end
        @(posedge clk); #1;
        req = 0; ld_req = 0;
        @(posedge clk); #1;
        rst_n = 1;
        idle(2);
    endtask

    task automatic test_load();
        idle(2);
        ld_req = 1; ld_addr = BASE + 32'h10; ld_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total++;
        if ({ld_gnt_o, mem_req_o, mem_we_o, gnt_o} !== 4'b1110) begin
            bad++; $display("FAIL load_ctrl: got %b want 1110", {ld_gnt_o, mem_req_o, mem_we_o, gnt_o});
        end
        total++;
        if (mem_addr_o !== AW'(4)) begin bad++; $display("FAIL load_addr: got %0d want 4", mem_addr_o); end
        total++;
        if (mem_wdata_o !== enc(32'hDEAD_BEEF)) begin bad++; $display("FAIL load_wdata: got %h want %h", mem_wdata_o, enc(32'hDEAD_BEEF)); end
        @(posedge clk); #1;
        ld_req = 0; req = 1; addr = BASE + 32'h13;
        @(negedge clk);
        total++;
        if ({gnt_o, mem_req_o, mem_we_o} !== 3'b110 || mem_addr_o !== AW'(4)) begin
            bad++; $display("FAIL fetch_issue: got %b addr %0d want 110 addr 4", {gnt_o, mem_req_o, mem_we_o}, mem_addr_o);
        end
        @(posedge clk); #1;
        req = 0;
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            total++;
            if (i < LAT) begin
                if (rvalid_o !== 1'b0) begin bad++; $display("FAIL fetch_early: cycle %0d got rvalid %b want 0", i, rvalid_o); end
            end else if ({rvalid_o, err_o} !== 2'b10 || rdata_o !== 32'hDEAD_BEEF) begin
                bad++; $display("FAIL fetch_resp: got v/e %b data %h want 10 deadbeef", {rvalid_o, err_o}, rdata_o);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] pat = 9'b011_011_011;
        idle(LAT + 1);
        req = 1; addr = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
        for (int i = 0; i < 9 + LAT; i++) begin
            if (i == 9) req = 0;
            @(negedge clk);
            eval();
            if (i < 9) begin
                total++;
                if (gnt_o !== pat[i]) begin bad++; $display("FAIL b2b_gnt: cycle %0d got %b want %b", i, gnt_o, pat[i]); end
            end
            total++;
            if ({rvalid_o, err_o} !== {m_rv, m_err} || rdata_o !== m_data) begin
                bad++; $display("FAIL b2b_resp: cycle %0d got %b %h want %b %h", i, {rvalid_o, err_o}, rdata_o, {m_rv, m_err}, m_data);
            end
            @(posedge clk); #1;
            if (i < 9 && pat[i]) addr = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] tbl [4] = '{BASE + 32'(4 * WORDS), BASE + 32'(4 * WORDS - 4), BASE - 32'd4, 32'h0};
        logic [3:0] oor = 4'b1101;
        logic [31:0] want;
        idle(LAT + 1);
        req = 1; addr = BASE + 32'd20;
        want = gm[5];
        @(negedge clk);
        total++;
        if ({gnt_o, mem_req_o} !== 2'b11) begin bad++; $display("FAIL oor_first: got %b want 11", {gnt_o, mem_req_o}); end
        @(posedge clk); #1;
        addr = BASE + 32'(4 * WORDS);
        @(negedge clk);
        total++;
        if ({gnt_o, mem_req_o} !== 2'b10) begin bad++; $display("FAIL oor_issue: got %b want 10", {gnt_o, mem_req_o}); end
        @(posedge clk); #1;
        req = 0;
        for (int k = 2; k <= LAT + 1; k++) begin
            @(negedge clk);
            total++;
            if (k == LAT) begin
                if ({rvalid_o, err_o} !== 2'b10 || rdata_o !== want) begin
                    bad++; $display("FAIL oor_order: got %b %h want 10 %h", {rvalid_o, err_o}, rdata_o, want);
                end
            end else if (k == LAT + 1) begin
                if ({rvalid_o, err_o} !== 2'b11 || rdata_o !== 32'h0) begin
                    bad++; $display("FAIL oor_resp: got %b %h want 11 0", {rvalid_o, err_o}, rdata_o);
                end
            end else if (rvalid_o !== 1'b0) begin
                bad++; $display("FAIL oor_early: got rvalid %b want 0", rvalid_o);
            end
            @(posedge clk); #1;
        end
        for (int t = 0; t < 4; t++) begin
            idle(1);
            req = 1; addr = tbl[t];
            @(negedge clk);
            total++;
            if ({gnt_o, mem_req_o} !== {1'b1, !oor[t]}) begin
                bad++; $display("FAIL bound_issue: addr %h got %b want %b", tbl[t], {gnt_o, mem_req_o}, {1'b1, !oor[t]});
            end
            @(posedge clk); #1;
            req = 0;
            repeat (LAT - 1) begin @(posedge clk); #1; end
            @(negedge clk);
            eval();
            total++;
            if ({rvalid_o, err_o} !== {1'b1, oor[t]} || rdata_o !== m_data) begin
                bad++; $display("FAIL bound_resp: addr %h got %b %h want %b %h", tbl[t], {rvalid_o, err_o}, rdata_o, {1'b1, oor[t]}, m_data);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_contention();
        logic [31:0] d = $urandom;
        idle(LAT + 1);
        req = 1; ld_req = 1; addr = BASE + 32'd8; ld_addr = BASE + 32'd8;
        for (int i = 0; i < 2; i++) begin
            ld_wdata = d ^ 32'(i);
            @(negedge clk);
            total++;
            if ({ld_gnt_o, gnt_o} !== 2'b10) begin bad++; $display("FAIL cont_arb: cycle %0d got %b want 10", i, {ld_gnt_o, gnt_o}); end
            @(posedge clk); #1;
        end
        ld_req = 0;
        @(negedge clk);
        total++;
        if (gnt_o !== 1'b1) begin bad++; $display("FAIL cont_release: got %b want 1", gnt_o); end
        @(posedge clk); #1;
        req = 0;
        repeat (LAT - 1) begin @(posedge clk); #1; end
        @(negedge clk);
        total++;
        if ({rvalid_o, err_o} !== 2'b10 || rdata_o !== (d ^ 32'd1)) begin
            bad++; $display("FAIL cont_data: got %b %h want 10 %h", {rvalid_o, err_o}, rdata_o, d ^ 32'd1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        idle(LAT + 1);
        req = 1; addr = BASE + 32'd12;
        @(negedge clk);
        total++;
        if (gnt_o !== 1'b1) begin bad++; $display("FAIL mid_gnt: got %b want 1", gnt_o); end
        @(posedge clk); #1;
        req = 0; rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            total++;
            if (rvalid_o !== 1'b0) begin bad++; $display("FAIL mid_ghost: cycle %0d got rvalid %b want 0", i, rvalid_o); end
            @(posedge clk); #1;
        end
        req = 1; addr = BASE + 32'd40;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (gnt_o !== 1'b1) begin bad++; $display("FAIL mid_regnt: cycle %0d got %b want 1", i, gnt_o); end
            @(posedge clk); #1;
        end
        req = 0;
        repeat (LAT - 2) begin @(posedge clk); #1; end
        @(negedge clk);
        total++;
        if ({rvalid_o, err_o} !== 2'b10 || rdata_o !== gm[10]) begin
            bad++; $display("FAIL mid_resp: got %b %h want 10 %h", {rvalid_o, err_o}, rdata_o, gm[10]);
        end
        idle(2);
    endtask

    task automatic test_parity();
        logic e_err;
        logic [31:0] e_data;
        idle(LAT + 1);
        req = 1; addr = BASE + 32'd28;
        @(posedge clk); #1;
        req = 0;
        repeat (LAT - 1) begin @(posedge clk); #1; end
        flip = DW'(32'h20);
        e_err = (PAR == 1);
        e_data = e_err ? 32'h0 : (gm[7] ^ 32'h20);
        @(negedge clk);
        total++;
        if ({rvalid_o, err_o} !== {1'b1, e_err} || rdata_o !== e_data) begin
            bad++; $display("FAIL parity: got %b %h want %b %h", {rvalid_o, err_o}, rdata_o, {1'b1, e_err}, e_data);
        end
        @(posedge clk); #1;
        flip = '0;
    endtask

    task automatic test_random();
        idle(LAT + 1);
        for (int i = 0; i < 400; i++) begin
            req = ($urandom % 4) != 0;
            ld_req = ($urandom % 5) == 0;
            addr = rnd_addr();
            ld_addr = rnd_addr();
            ld_wdata = $urandom;
            flip = (($urandom % 10) == 0) ? (DW'(1) << $urandom_range(0, DW - 1)) : '0;
            @(negedge clk);
            eval();
            total++;
            if ({gnt_o, ld_gnt_o} !== {m_gnt, ld_req}) begin
                bad++; $display("FAIL rnd_grant: cycle %0d got %b want %b", i, {gnt_o, ld_gnt_o}, {m_gnt, ld_req});
            end
            total++;
            if ({rvalid_o, err_o} !== {m_rv, m_err} || rdata_o !== m_data) begin
                bad++; $display("FAIL rnd_resp: cycle %0d got %b %h want %b %h", i, {rvalid_o, err_o}, rdata_o, {m_rv, m_err}, m_data);
            end
            total++;
            if ({mem_req_o, mem_we_o} !== {m_mreq, m_we} || mem_addr_o !== m_maddr) begin
                bad++; $display("FAIL rnd_mem: cycle %0d got %b %h want %b %h", i, {mem_req_o, mem_we_o}, mem_addr_o, {m_mreq, m_we}, m_maddr);
            end
            total++;
            if (mem_wdata_o !== (m_we ? enc(ld_wdata) : '0)) begin
                bad++; $display("FAIL rnd_wdata: cycle %0d got %h want %h", i, mem_wdata_o, m_we ? enc(ld_wdata) : '0);
            end
            @(posedge clk); #1;
        end
        flip = '0;
        idle(LAT + 1);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; flip = '0;
        for (int i = 0; i < WORDS; i++) begin
            gm[i] = $urandom;
            sram[i] = enc(gm[i]);
        end
        for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;
        test_reset();
        test_load();
        test_back_to_back();
        test_out_of_range();
        test_contention();
        test_reset_midflight();
        test_parity();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
